// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Used by nibble_serial_adder_ctrl (optional subtract path: NSA_SUB_EN).
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Index register width; never narrower than one bit.
  function automatic int idx_w(input int nibbles);
    return ($clog2(nibbles) < 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Also exports the carry into bit 3 so the caller can derive signed overflow.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = x ^ y;
  assign g = x & y;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder sharing one cla4_slice across nibbles, LSB first.
// Define NSA_SUB_EN to add the op_sub port and A - B support.
//
// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one nibble added per cycle, idx selects the nibble
// DONE  | result valid, done pulses; start here begins a new operation
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_w(NIBBLES);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  state_t             state, state_next;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [IW-1:0]      idx;
  logic [IW+1:0]      base;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q;
  logic [3:0]         slice_s;
  logic               slice_co, slice_c3;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

`ifdef NSA_SUB_EN
  assign b_load     = op_sub ? ~b : b;
  assign carry_load = op_sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign base = {idx, 2'b00};

  cla4_slice u_slice (
    .x    (a_q[base +: NIBBLE_W]),
    .y    (b_q[base +: NIBBLE_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == IDX_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-nibble result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_load;
      carry_q <= carry_load;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == RUN) begin
      sum_q[base +: NIBBLE_W] <= slice_s;
      carry_q                 <= slice_co;
      idx                     <= idx + IDX_ONE;
      if (last) begin
        cout_q <= slice_co;
        ovf_q  <= slice_c3 ^ slice_co;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=32).
// Reference model is plain 33-bit arithmetic; honours NSA_SUB_EN when defined.
module tb_nibble_serial_adder_ctrl;

  localparam int W       = 32;
  localparam int NIB     = W / 4;
  localparam int TIMEOUT = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef NSA_SUB_EN
    .op_sub (sub),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {ovf, cout, sum} from the arithmetic definition of add / subtract.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   t;
    logic         v;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    a = x; b = y; cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
      checks++;
      if ({busy, done, cout, ovf, sum} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                 i, busy, done, sum, cout, ovf);
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d pulses want 0", pulses);
    end
  endtask

  // One complete operation with latency, busy, result and hold checks.
  task automatic run_one(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s);
    logic [W+1:0] exp;
    int lat, busy_bad;
    exp = ref_op(x, y, c, s);
    issue(x, y, c, s);
    checks++;
    if (sum !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept got sum=%h busy=%b want sum=0 busy=1", name, sum, busy);
    end
    busy_bad = 0;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      if (!busy) busy_bad++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NIB || busy_bad !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency got %0d busy_gaps=%0d busy_at_done=%b want %0d 0 0",
               name, lat, busy_bad, busy, NIB);
    end
    checks++;
    if ({ovf, cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ovf, cout, sum} !== exp || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold got sum=%h cout=%b ovf=%b done=%b want sum=%h cout=%b ovf=%b done=0",
               name, sum, cout, ovf, done, exp[W-1:0], exp[W], exp[W+1]);
    end
  endtask

  task automatic test_carry_out();
    run_one("carry_out", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    run_one("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [W-1:0] got;
    pulses = 0;
    got = '0;
    issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        pulses++;
        got = sum;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1 || got !== 32'h2345_678A) begin
      errors++;
      $display("FAIL start_ignored got pulses=%0d sum=%h want 1 %h", pulses, got, 32'h2345_678A);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, lat, t1, t2;
    issue(32'hCAFE_0001, 32'h0000_1234, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sum !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run got sum=%h busy=%b done=%b want 0 0 0", sum, busy, done);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || sum !== '0) begin
      errors++;
      $display("FAIL reset_mid_no_done got pulses=%0d sum=%h want 0 0", pulses, sum);
    end
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(lat);
    t1 = cyc;
    checks++;
    if (lat !== NIB || sum !== 32'd7 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d sum=%h cout=%b want %0d 7 0", lat, sum, cout, NIB);
    end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(lat);
    t2 = cyc;
    checks++;
    if (sum !== 32'hFFFF_FFFE || cout !== 1'b1 || ovf !== 1'b0 || (t2 - t1) !== NIB + 1) begin
      errors++;
      $display("FAIL b2b_second got sum=%h cout=%b ovf=%b gap=%0d want FFFFFFFE 1 0 %0d",
               sum, cout, ovf, t2 - t1, NIB + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic c;
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      c = 1'($urandom_range(0, 1));
      if (i == 0) x = 32'h8000_0000;
      if (i == 0) y = 32'h8000_0000;
      run_one("random", x, y, c, 1'b0);
    end
  endtask

`ifdef NSA_SUB_EN
  task automatic test_sub();
    logic [W-1:0] x, y;
    run_one("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1);
    run_one("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom;
      run_one("sub_random", x, y, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_carry_out();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_random();
`ifdef NSA_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
